wb_cell_sweep: RTL and testbench
================================

// Module: wb_cell_sweep
// PURPOSE
//  Wishbone-slave stimulus/capture engine: the management SoC side of the standard-cell test path.
//  Drives input pattern stim_o into one cell under test and samples the cell output resp_i.
//  Sweeps all 2^N_IN input combinations and records the cell's truth table in RESULT.
//  Also provides manual static drive, for bring-up of the standard-cell testwafer.
// PARAMETERS
//  BASE_ADR  32'h3000_0000  block base; decode adr[31:4]==BASE_ADR[31:4]
//  NIN       5              stim_o width / max inputs swept (legal 1..5, RESULT is 32 bits)
// PORTS
//  wb_clk_i    in   1    sole clock
//  wb_rst_i    in   1    reset; synchronous, active-high
//  wbs_stb_i   in   1    WB strobe
//  wbs_cyc_i   in   1    WB cycle
//  wbs_we_i    in   1    WB write enable
//  wbs_sel_i   in   4    WB byte selects
//  wbs_dat_i   in   32   WB write data
//  wbs_adr_i   in   32   WB byte address
//  wbs_ack_o   out  1    WB acknowledge
//  wbs_dat_o   out  32   WB read data
//  stim_o      out  NIN  cell-under-test inputs
//  resp_i      in   1    cell-under-test output; asynchronous, 2-flop synchronised internally
//  busy_o      out  1    sweep in progress
//  irq_o       out  1    equals STATUS.DONE
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, all registers 0, synchroniser flops 0.
//  WB: a matched stb&cyc gets ack exactly 1 cycle later; ack lasts 1 cycle, then stays low >=1 cycle.
//   Unmatched address: no ack. Read data is valid with ack, else 0. Writes honour wbs_sel_i per byte.
//  Registers, offset adr[3:2]:
//   0x0 CTRL   [0] START (write-1 pulse, reads 0), [6:4] N_IN, [15:8] SETTLE (0 means 1)
//   0x4 STATUS [0] BUSY (RO), [1] DONE (sticky, W1C), [2] ERR (RO)
//   0x8 RESULT [k] = resp for pattern k; bits >= 2^N_IN read 0 (RO)
//   0xC STIM   [NIN-1:0] manual drive, RW; [31] = synchronised resp_i (RO)
//  stim_o = STIM while IDLE; stim_o = pattern while sweeping.
//  FSM:
//   IDLE
//    - START with 1<=N_IN<=NIN: RESULT<=0, ERR<=0, pattern<=0 -> APPLY.
//    - START with N_IN illegal: ERR<=1, stay IDLE, DONE unchanged.
//   APPLY: stim_o<=pattern, cnt<=SETTLE+2 -> WAIT.
//   WAIT: decrement cnt each cycle; cnt==1 -> CAPTURE. WAIT lasts SETTLE+2 cycles and covers the synchroniser.
//   CAPTURE: RESULT[pattern]<=resp_sync.
//    - pattern==2^N_IN-1 -> FINISH.
//    - else pattern+1 -> APPLY.
//   FINISH: DONE<=1 -> IDLE.
//  Timing: per pattern = SETTLE+4 cycles. busy_o spans 2^N_IN*(SETTLE+4)+1 cycles, from the cycle after the START write.
//  busy_o is high in APPLY, WAIT, CAPTURE and FINISH.
//  Pattern order is ascending 0..2^N_IN-1; stim bits >= N_IN are 0 during a sweep.
//  While BUSY: START, CTRL writes and STIM writes are ignored; reads still ack.
//  DONE set (FINISH) and W1C clear in the same cycle: set wins.
//  Reset mid-sweep: next cycle FSM IDLE, RESULT=0, stim_o=0; no DONE.
// TESTING
//  1. Reset, then read all four registers -> 0, except STIM[31] which equals resp_i two cycles delayed.
//  2. AND2 model (resp=s0&s1), N_IN=2, SETTLE=3 -> RESULT=0x8, busy 29 cycles, DONE=1, irq_o=1.
//  3. Models XOR2 / NAND3 / MUX2 (Y=s2?s1:s0) -> RESULT=0x6 / 0x7F / 0xCA.
//  4. 5-input parity, N_IN=5, SETTLE=0 -> RESULT=0x96696996, busy 32*5+1=161 cycles.
//  5. Error and interference cases:
//     - START with N_IN=0 -> ERR=1, no busy.
//     - START, STIM write and CTRL write during a sweep -> no effect.
//     - W1C of DONE on the FINISH cycle -> DONE=1.
//  6. Reset asserted mid-sweep -> IDLE, stim_o=0, RESULT=0.
//     Access to BASE_ADR+0x10 -> no ack within 8 cycles.

Source files
------------

// File: rtl/wb_cell_sweep.sv
// Wishbone-slave stimulus/capture engine for the standard-cell test path.
// Sweeps every input combination of one cell under test and records its
// truth table. It also offers a static manual drive for bring-up.
module wb_cell_sweep #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int          NIN      = 5
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [NIN-1:0]  stim_o,
  input  logic            resp_i,
  output logic            busy_o,
  output logic            irq_o
);

  localparam logic [2:0] NIN_W = 3'(NIN);

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CAPTURE, FINISH} state_t;

  state_t          state_reg, state_next;
  logic            ack_reg;
  logic [31:0]     dat_reg;
  logic [2:0]      n_in_reg;
  logic [7:0]      settle_reg;
  logic            done_reg;
  logic            err_reg;
  logic [31:0]     result_reg;
  logic [NIN-1:0]  stim_reg;
  logic [4:0]      pattern_reg;
  logic [8:0]      cnt_reg;
  logic            resp_meta_reg;
  logic            resp_sync_reg;

  logic            hit, accept, wr_en, idle;
  logic            ctrl_wr, status_wr, stim_wr;
  logic            start, start_ok, last_hit;
  logic [1:0]      reg_sel;
  logic [2:0]      n_in_wr;
  logic [7:0]      settle_eff;
  logic [4:0]      last_pat;
  logic [31:0]     result_mask;
  logic [31:0]     rdata;
  logic            unused_bits;

  // Bus decode: one access is taken per ack, so ack always drops for a cycle.
  assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign accept    = hit & ~ack_reg;
  assign wr_en     = accept & wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign idle      = (state_reg == IDLE);
  assign ctrl_wr   = wr_en & (reg_sel == 2'd0) & idle;
  assign status_wr = wr_en & (reg_sel == 2'd1);
  assign stim_wr   = wr_en & (reg_sel == 2'd3) & idle & wbs_sel_i[0];

  // START is judged against the N_IN value written in the same access.
  assign n_in_wr   = wbs_sel_i[0] ? wbs_dat_i[6:4] : n_in_reg;
  assign start     = ctrl_wr & wbs_sel_i[0] & wbs_dat_i[0];
  assign start_ok  = (n_in_wr != 3'd0) && (n_in_wr <= NIN_W);

  assign settle_eff = (settle_reg == 8'd0) ? 8'd1 : settle_reg;
  assign last_pat   = 5'((6'd1 << n_in_reg) - 6'd1);
  assign last_hit   = (pattern_reg == last_pat);

  // Bits beyond the swept patterns never show in RESULT, even after N_IN is changed.
  always_comb begin
    result_mask = 32'hFFFF_FFFF;
    case (n_in_reg)
      3'd0:    result_mask = 32'h0000_0001;
      3'd1:    result_mask = 32'h0000_0003;
      3'd2:    result_mask = 32'h0000_000F;
      3'd3:    result_mask = 32'h0000_00FF;
      3'd4:    result_mask = 32'h0000_FFFF;
      default: result_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Register read multiplexer.
  always_comb begin
    rdata = 32'h0;
    case (reg_sel)
      2'd0: rdata = {16'h0, settle_reg, 1'b0, n_in_reg, 4'h0};
      2'd1: rdata = {29'h0, err_reg, done_reg, ~idle};
      2'd2: rdata = result_reg & result_mask;
      2'd3: rdata = {resp_sync_reg, {(31-NIN){1'b0}}, stim_reg};
      default: rdata = 32'h0;
    endcase
  end

  // Next-state logic for the sweep sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && start_ok) state_next = APPLY;
      APPLY:   state_next = WAIT;
      WAIT:    if (cnt_reg == 9'd1) state_next = CAPTURE;
      CAPTURE: state_next = last_hit ? FINISH : APPLY;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Bus response: ack one cycle after an accepted access, data only on reads.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg <= 1'b0;
      dat_reg <= 32'h0;
    end else begin
      ack_reg <= accept;
      dat_reg <= (accept & ~wbs_we_i) ? rdata : 32'h0;
    end
  end

  // Two-flop synchroniser for the asynchronous cell output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      resp_meta_reg <= 1'b0;
      resp_sync_reg <= 1'b0;
    end else begin
      resp_meta_reg <= resp_i;
      resp_sync_reg <= resp_meta_reg;
    end
  end

  // Configuration and manual drive; frozen while a sweep runs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      n_in_reg   <= 3'd0;
      settle_reg <= 8'd0;
      stim_reg   <= '0;
    end else begin
      if (ctrl_wr && wbs_sel_i[0]) n_in_reg   <= wbs_dat_i[6:4];
      if (ctrl_wr && wbs_sel_i[1]) settle_reg <= wbs_dat_i[15:8];
      if (stim_wr)                 stim_reg   <= wbs_dat_i[NIN-1:0];
    end
  end

  // Status flags: DONE set by the sequencer beats a simultaneous W1C.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (state_reg == FINISH)
        done_reg <= 1'b1;
      else if (status_wr && wbs_sel_i[0] && wbs_dat_i[1])
        done_reg <= 1'b0;
      if (start) err_reg <= ~start_ok;
    end
  end

  // Sweep datapath: pattern counter, settle timer and truth-table capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pattern_reg <= 5'd0;
      cnt_reg     <= 9'd0;
      result_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && start_ok) begin
            pattern_reg <= 5'd0;
            result_reg  <= 32'h0;
          end
        end
        APPLY:   cnt_reg <= {1'b0, settle_eff} + 9'd2;
        WAIT:    cnt_reg <= cnt_reg - 9'd1;
        CAPTURE: begin
          result_reg[pattern_reg] <= resp_sync_reg;
          if (!last_hit) pattern_reg <= pattern_reg + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign busy_o    = ~idle;
  assign irq_o     = done_reg;
  assign stim_o    = idle ? stim_reg : pattern_reg[NIN-1:0];

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_dat_i[7], wbs_sel_i[3:2]};

endmodule

// File: tb/tb_wb_cell_sweep.sv
// Bench for wb_cell_sweep: directed Wishbone accesses against small cell
// models, with a queue-based scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_wb_cell_sweep;

  localparam logic [31:0] A_CTRL   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_RESULT = 32'h3000_0008;
  localparam logic [31:0] A_STIM   = 32'h3000_000C;
  localparam logic [31:0] A_BAD    = 32'h3000_0010;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [4:0]  stim_o;
  logic        resp_i;
  logic        busy_o;
  logic        irq_o;

  int          model = 0;

  wb_cell_sweep #(.BASE_ADR(32'h3000_0000), .NIN(5)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .stim_o(stim_o), .resp_i(resp_i), .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Cell-under-test models.
  always_comb begin
    case (model)
      0:       resp_i = 1'b1;
      1:       resp_i = stim_o[0] & stim_o[1];
      2:       resp_i = stim_o[0] ^ stim_o[1];
      3:       resp_i = ~(stim_o[0] & stim_o[1] & stim_o[2]);
      4:       resp_i = stim_o[2] ? stim_o[1] : stim_o[0];
      default: resp_i = ^stim_o;
    endcase
  end

  typedef struct { string name; logic [31:0] exp; logic [31:0] mask; } sb_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } ck_t;
  sb_t sb_q[$];
  ck_t ck_q[$];
  int  tests = 0;
  int  fails = 0;

  // Busy-window tracker: length of the last busy pulse and OR of stim seen in it.
  int          busy_len = 0;
  int          last_len = 0;
  logic [4:0]  stim_or = 5'h0;
  logic [4:0]  last_or = 5'h0;
  always @(negedge wb_clk_i) begin
    if (busy_o) begin
      busy_len <= busy_len + 1;
      stim_or  <= (busy_len == 0) ? stim_o : (stim_or | stim_o);
    end else if (busy_len != 0) begin
      last_len <= busy_len;
      last_or  <= stim_or;
      busy_len <= 0;
    end
  end

  // Monitor: pops the scoreboard on each ack and drains direct checks.
  initial begin
    sb_t e;
    ck_t c;
    forever begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_ack got dat=%h required no ack", wbs_dat_o);
        end else begin
          e = sb_q.pop_front();
          if (e.mask != 32'h0) begin
            tests++;
            if ((wbs_dat_o & e.mask) !== (e.exp & e.mask)) begin
              fails++;
              $display("[TB] FAIL %s got %h required %h", e.name, wbs_dat_o, e.exp);
            end else
              $display("[TB] read %s = %h", e.name, wbs_dat_o);
          end else
            $display("[TB] write %s acked", e.name);
        end
      end
      while (ck_q.size() > 0) begin
        c = ck_q.pop_front();
        tests++;
        if (c.act !== c.exp) begin
          fails++;
          $display("[TB] FAIL %s got %h required %h", c.name, c.act, c.exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ck_t c;
    c.name = nm; c.act = act; c.exp = exp;
    ck_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // One bus access, bounded to 8 cycles; called just after a rising edge.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic got);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin got = 1'b1; break; end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    sb_t s;
    logic got;
    s.name = nm; s.exp = exp; s.mask = 32'hFFFF_FFFF;
    sb_q.push_back(s);
    xfer(1'b0, adr, 32'h0, 4'hF, got);
    if (!got) chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                    input string nm);
    sb_t s;
    logic got;
    s.name = nm; s.exp = 32'h0; s.mask = 32'h0;
    sb_q.push_back(s);
    xfer(1'b1, adr, dat, sel, got);
    if (!got) chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy_o && n < 2000) begin tick(1); n++; end
    if (busy_o) chk({nm, "_busy_timeout"}, 32'd1, 32'd0);
    tick(1);
  endtask

  task automatic sweep(input int mdl, input int n, input int settle,
                       input logic [31:0] exp_res, input int exp_busy, input string nm);
    model = mdl;
    wr(A_STATUS, 32'h2, 4'hF, {nm, "_clr"});
    wr(A_CTRL, 32'((settle << 8) | (n << 4) | 1), 4'hF, {nm, "_start"});
    wait_idle(nm);
    chk({nm, "_busy_cycles"}, 32'(last_len), 32'(exp_busy));
    chk({nm, "_stim_span"}, {27'h0, last_or}, 32'((1 << n) - 1));
    chk({nm, "_irq"}, {31'h0, irq_o}, 32'h1);
    rd(A_STATUS, 32'h2, {nm, "_status"});
    rd(A_RESULT, exp_res, {nm, "_result"});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    // 1. Reset state.
    model = 0;
    tick(3);
    chk("rst_ack",  {31'h0, wbs_ack_o}, 32'h0);
    chk("rst_dat",  wbs_dat_o, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_irq",  {31'h0, irq_o}, 32'h0);
    chk("rst_stim", {27'h0, stim_o}, 32'h0);
    wb_rst_i = 1'b0;
    tick(3);
    rd(A_CTRL,   32'h0, "ctrl_reset");
    rd(A_STATUS, 32'h0, "status_reset");
    rd(A_RESULT, 32'h0, "result_reset");
    rd(A_STIM,   32'h8000_0000, "stim_reset");

    // Manual drive and byte selects.
    model = 1;
    wr(A_STIM, 32'h15, 4'hF, "stim_wr15");
    chk("stim_o_15", {27'h0, stim_o}, 32'h15);
    tick(3);
    rd(A_STIM, 32'h0000_0015, "stim_rd15");
    wr(A_STIM, 32'h1B, 4'h0, "stim_wr_nosel");
    chk("stim_o_nosel", {27'h0, stim_o}, 32'h15);
    wr(A_STIM, 32'h1B, 4'h1, "stim_wr1b");
    tick(3);
    rd(A_STIM, 32'h8000_001B, "stim_rd1b");

    // 2-4. Sweeps.
    sweep(1, 2, 3, 32'h0000_0008, 29, "and2");
    rd(A_CTRL, 32'h0000_0320, "ctrl_after_and2");
    sweep(2, 2, 3, 32'h0000_0006, 29, "xor2");
    sweep(3, 3, 2, 32'h0000_007F, 49, "nand3");
    sweep(4, 3, 1, 32'h0000_00CA, 41, "mux2");
    sweep(5, 5, 0, 32'h9669_6996, 161, "par5");

    // 5a. Illegal N_IN.
    wr(A_CTRL, 32'h001, 4'hF, "start_n0");
    chk("n0_no_busy", {31'h0, busy_o}, 32'h0);
    rd(A_STATUS, 32'h6, "n0_status");
    wr(A_CTRL, 32'h061, 4'hF, "start_n6");
    chk("n6_no_busy", {31'h0, busy_o}, 32'h0);
    rd(A_STATUS, 32'h6, "n6_status");

    // 5b. Interference during a sweep.
    model = 1;
    wr(A_STATUS, 32'h2, 4'hF, "intf_clr");
    wr(A_CTRL, 32'h321, 4'hF, "intf_start");
    wr(A_STIM, 32'h04, 4'hF, "intf_stim_wr");
    wr(A_CTRL, 32'h0F51, 4'hF, "intf_ctrl_wr");
    rd(A_STATUS, 32'h1, "intf_status_busy");
    wait_idle("intf");
    chk("intf_busy_cycles", 32'(last_len), 32'd29);
    rd(A_RESULT, 32'h8, "intf_result");
    rd(A_CTRL, 32'h320, "intf_ctrl");
    rd(A_STIM, 32'h8000_001B, "intf_stim");

    // 5c. W1C landing on the FINISH cycle.
    model = 2;
    wr(A_STATUS, 32'h2, 4'hF, "fin_clr");
    wr(A_CTRL, 32'h011, 4'hF, "fin_start");
    tick(10);
    wr(A_STATUS, 32'h2, 4'hF, "fin_w1c");
    rd(A_STATUS, 32'h2, "fin_done_wins");
    tick(1);
    chk("fin_busy_cycles", 32'(last_len), 32'd11);
    rd(A_RESULT, 32'h2, "fin_result");
    wr(A_STATUS, 32'h2, 4'hE, "w1c_nosel");
    rd(A_STATUS, 32'h2, "w1c_nosel_status");
    wr(A_STATUS, 32'h2, 4'h1, "w1c");
    rd(A_STATUS, 32'h0, "w1c_status");
    chk("w1c_irq", {31'h0, irq_o}, 32'h0);

    // 6. Reset mid-sweep, then an unmapped access.
    model = 3;
    wr(A_CTRL, 32'h331, 4'hF, "mid_start");
    tick(10);
    wb_rst_i = 1'b1;
    tick(1);
    wb_rst_i = 1'b0;
    chk("mid_busy", {31'h0, busy_o}, 32'h0);
    chk("mid_stim", {27'h0, stim_o}, 32'h0);
    chk("mid_irq",  {31'h0, irq_o}, 32'h0);
    tick(3);
    rd(A_RESULT, 32'h0, "mid_result");
    rd(A_STATUS, 32'h0, "mid_status");
    rd(A_CTRL,   32'h0, "mid_ctrl");
    rd(A_STIM,   32'h8000_0000, "mid_stim_rd");
    xfer(1'b0, A_BAD, 32'h0, 4'hF, got);
    chk("bad_adr_no_ack", {31'h0, got}, 32'h0);

    tick(3);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
